div_rsv_dispatch: RTL and testbench

DIV_RSV_DISPATCH -- requirements
Module: div_rsv_dispatch

---
 rtl/div_rsv_dispatch_if.sv | 32 +++
 rtl/div_rsv_dispatch.sv | 88 ++++++++
 tb/tb_div_rsv_dispatch.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/div_rsv_dispatch_if.sv
// rtl/div_rsv_dispatch_if.sv - push, flush and scoreboard dispatch signals of the divide reservation queue
interface div_rsv_dispatch_if #(
  parameter int W_PA_REG     = 5,
  parameter int W_PD_UOPS    = 6,
  parameter int W_PC_SEL_RSV = 2,
  parameter int W_PC_SEL_ODR = 2
);
  logic [W_PD_UOPS-1:0]    CDI_PD_uops;
  logic [W_PA_REG-1:0]     CDI_PD_rd;
  logic                    CDI_PC_push;
  logic                    CDO_PC_full;
  logic                    CDO_PC_empty;
  logic [W_PD_UOPS-1:0]    CDO_PD_uops0;
  logic [W_PD_UOPS-1:0]    CDO_PD_uops1;
  logic [W_PA_REG-1:0]     CDO_PD_rd0;
  logic [W_PA_REG-1:0]     CDO_PD_rd1;
  logic [W_PC_SEL_ODR-1:0] CDO_PC_odr;
  logic [W_PC_SEL_RSV-1:0] CDI_PC_selrsv;
  logic                    CFI_PC_clear;

  modport master (
    output CDI_PD_uops, CDI_PD_rd, CDI_PC_push, CDI_PC_selrsv, CFI_PC_clear,
    input  CDO_PC_full, CDO_PC_empty, CDO_PD_uops0, CDO_PD_uops1,
    input  CDO_PD_rd0, CDO_PD_rd1, CDO_PC_odr
  );

  modport slave (
    input  CDI_PD_uops, CDI_PD_rd, CDI_PC_push, CDI_PC_selrsv, CFI_PC_clear,
    output CDO_PC_full, CDO_PC_empty, CDO_PD_uops0, CDO_PD_uops1,
    output CDO_PD_rd0, CDO_PD_rd1, CDO_PC_odr
  );
endinterface

// File: rtl/div_rsv_dispatch.sv
// rtl/div_rsv_dispatch.sv - single-issue divide reservation queue with alternating pipe order request
module div_rsv_dispatch #(
  parameter int W_PA_REG     = 5,
  parameter int W_PD_UOPS    = 6,
  parameter int W_PC_SEL_RSV = 2,
  parameter int W_PC_SEL_ODR = 2,
  parameter int S_depth      = 4,
  parameter int W_cnt        = 3,
  parameter logic [W_PD_UOPS-1:0]    unused_op = {W_PD_UOPS{1'b1}},
  parameter logic [W_PC_SEL_ODR-1:0] V_unpip   = 2'b00,
  parameter logic [W_PC_SEL_ODR-1:0] V_odrf0   = 2'b01,
  parameter logic [W_PC_SEL_ODR-1:0] V_odrf1   = 2'b10
) (
  input logic              clk,
  input logic              rst_n,
  div_rsv_dispatch_if.slave bus
);
  localparam int PW = (S_depth > 1) ? $clog2(S_depth) : 1;
  localparam logic [PW-1:0]    LAST_PTR = PW'(S_depth - 1);
  localparam logic [W_cnt-1:0] DEPTH_CNT = W_cnt'(S_depth);

  typedef enum logic {ODR0, ODR1} pref_t;

  logic [W_PD_UOPS-1:0] uops_mem [S_depth];
  logic [W_PA_REG-1:0]  rd_mem   [S_depth];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [W_cnt-1:0]     count;
  pref_t                pref, pref_next;
  logic                 empty, full, push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // Push eligibility looks at the pre-pop count, so a push into a full queue is dropped even while popping.
  assign push_ok = bus.CDI_PC_push && (bus.CDI_PD_uops != unused_op) && !full && !bus.CFI_PC_clear;
  assign pop_ok  = !empty && (bus.CDI_PC_selrsv != V_unpip) && !bus.CFI_PC_clear;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      uops_mem[wr_ptr] <= bus.CDI_PD_uops;
      rd_mem[wr_ptr]   <= bus.CDI_PD_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.CFI_PC_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + W_cnt'(1);
        2'b01:   count <= count - W_cnt'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pref <= ODR0;
    else        pref <= pref_next;
  end

  // Pref flips on any occupied cycle: accepted heads alternate pipes, rejected heads retry the other pipe.
  always_comb begin
    pref_next = pref;
    if (bus.CFI_PC_clear)  pref_next = ODR0;
    else if (!empty)       pref_next = (pref == ODR0) ? ODR1 : ODR0;
  end

  assign bus.CDO_PC_full  = full;
  assign bus.CDO_PC_empty = empty;
  assign bus.CDO_PD_uops0 = empty ? unused_op : uops_mem[rd_ptr];
  assign bus.CDO_PD_rd0   = empty ? '0 : rd_mem[rd_ptr];
  assign bus.CDO_PD_uops1 = unused_op;
  assign bus.CDO_PD_rd1   = '0;
  assign bus.CDO_PC_odr   = empty ? V_unpip : ((pref == ODR0) ? V_odrf0 : V_odrf1);
endmodule

// File: tb/tb_div_rsv_dispatch.sv
// tb/tb_div_rsv_dispatch.sv - directed vectors for the divide reservation dispatcher
module tb_div_rsv_dispatch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  div_rsv_dispatch_if bus ();
  div_rsv_dispatch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.CDI_PC_push   = 1'b0;
    bus.CDI_PD_uops   = 6'h3F;
    bus.CDI_PD_rd     = '0;
    bus.CDI_PC_selrsv = 2'b00;
    bus.CFI_PC_clear  = 1'b0;
  endtask

  task automatic flush();
    bus.CFI_PC_clear = 1'b1;
    step();
    bus.CFI_PC_clear = 1'b0;
  endtask

  task automatic push(input logic [5:0] u, input logic [4:0] r);
    bus.CDI_PC_push = 1'b1;
    bus.CDI_PD_uops = u;
    bus.CDI_PD_rd   = r;
    step();
    bus.CDI_PC_push = 1'b0;
    bus.CDI_PD_uops = 6'h3F;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".uops0"}, 32'(bus.CDO_PD_uops0), 32'h3F);
    chk({tag, ".rd0"},   32'(bus.CDO_PD_rd0),   32'h0);
    chk({tag, ".uops1"}, 32'(bus.CDO_PD_uops1), 32'h3F);
    chk({tag, ".rd1"},   32'(bus.CDO_PD_rd1),   32'h0);
    chk({tag, ".odr"},   32'(bus.CDO_PC_odr),   32'h0);
    chk({tag, ".empty"}, 32'(bus.CDO_PC_empty), 32'h1);
    chk({tag, ".full"},  32'(bus.CDO_PC_full),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] exp_seq [5];
    exp_seq[0] = 6'h02; exp_seq[1] = 6'h03; exp_seq[2] = 6'h04;
    exp_seq[3] = 6'h07; exp_seq[4] = 6'h08;

    idle();
    #1;
    chk_reset_vals("reset");
    step();
    rst_n = 1'b1;
    step();

    // Idle-code push is ignored
    push(6'h3F, 5'd1);
    chk("idle_push.empty", 32'(bus.CDO_PC_empty), 32'h1);

    // Single push then accept
    push(6'h05, 5'd3);
    chk("single.uops0", 32'(bus.CDO_PD_uops0), 32'h05);
    chk("single.rd0",   32'(bus.CDO_PD_rd0),   32'h3);
    chk("single.odr",   32'(bus.CDO_PC_odr),   32'h1);
    bus.CDI_PC_selrsv = 2'b01;
    step();
    bus.CDI_PC_selrsv = 2'b00;
    chk("single.empty", 32'(bus.CDO_PC_empty), 32'h1);
    chk("single.odr_idle", 32'(bus.CDO_PC_odr), 32'h0);

    // Fill past capacity, then drain with alternating order
    flush();
    for (int i = 1; i <= 4; i++) push(6'(i), 5'(i));
    chk("fill.full", 32'(bus.CDO_PC_full), 32'h1);
    push(6'h05, 5'd5);
    chk("fill.full_after_drop", 32'(bus.CDO_PC_full), 32'h1);
    bus.CDI_PC_selrsv = 2'b01;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain.uops0[%0d]", i), 32'(bus.CDO_PD_uops0), 32'(i + 1));
      chk($sformatf("drain.odr[%0d]", i), 32'(bus.CDO_PC_odr), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    bus.CDI_PC_selrsv = 2'b00;
    chk("drain.empty", 32'(bus.CDO_PC_empty), 32'h1);

    // Rejected head retries the other pipe without moving
    flush();
    push(6'h0A, 5'd7);
    chk("retry.odr0", 32'(bus.CDO_PC_odr), 32'h1);
    step();
    chk("retry.odr1", 32'(bus.CDO_PC_odr), 32'h2);
    chk("retry.uops0", 32'(bus.CDO_PD_uops0), 32'h0A);
    step();
    chk("retry.odr2", 32'(bus.CDO_PC_odr), 32'h1);
    chk("retry.rd0", 32'(bus.CDO_PD_rd0), 32'h7);
    chk("retry.empty", 32'(bus.CDO_PC_empty), 32'h0);

    // Push while full and popping is dropped; push+pop through pointer wrap keeps order
    flush();
    for (int i = 1; i <= 4; i++) push(6'(i), 5'(i));
    bus.CDI_PC_selrsv = 2'b01;
    push(6'h06, 5'd6);
    chk("wrap.full", 32'(bus.CDO_PC_full), 32'h0);
    chk("wrap.head0", 32'(bus.CDO_PD_uops0), 32'(exp_seq[0]));
    step();
    chk("wrap.head1", 32'(bus.CDO_PD_uops0), 32'(exp_seq[1]));
    push(6'h07, 5'd7);
    chk("wrap.head2", 32'(bus.CDO_PD_uops0), 32'(exp_seq[2]));
    push(6'h08, 5'd8);
    chk("wrap.head3", 32'(bus.CDO_PD_uops0), 32'(exp_seq[3]));
    step();
    chk("wrap.head4", 32'(bus.CDO_PD_uops0), 32'(exp_seq[4]));
    chk("wrap.rd4", 32'(bus.CDO_PD_rd0), 32'h8);
    step();
    bus.CDI_PC_selrsv = 2'b00;
    chk("wrap.empty", 32'(bus.CDO_PC_empty), 32'h1);

    // Clear beats simultaneous push and pop
    flush();
    for (int i = 1; i <= 3; i++) push(6'(i), 5'(i));
    bus.CFI_PC_clear  = 1'b1;
    bus.CDI_PC_push   = 1'b1;
    bus.CDI_PD_uops   = 6'h09;
    bus.CDI_PC_selrsv = 2'b01;
    step();
    idle();
    chk("clear.empty", 32'(bus.CDO_PC_empty), 32'h1);
    chk("clear.uops0", 32'(bus.CDO_PD_uops0), 32'h3F);
    chk("clear.odr", 32'(bus.CDO_PC_odr), 32'h0);

    // Asynchronous reset mid-operation
    push(6'h11, 5'd1);
    push(6'h12, 5'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    step();
    rst_n = 1'b1;
    push(6'h0B, 5'd4);
    chk("postreset.uops0", 32'(bus.CDO_PD_uops0), 32'h0B);
    chk("postreset.odr", 32'(bus.CDO_PC_odr), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
